// File: rtl/mult_pkg.sv
// Shared constants and state encoding for the sequential shift-add multiplier.
package mult_pkg;

    localparam int unsigned DEF_WIDTH = 8;
    localparam int unsigned DEF_CNT_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        CALC = 2'b01,
        DONE = 2'b10
    } state_t;

endpackage

// File: rtl/mult_seq_8bits_if.sv
// Operand/result bundle between the multiplier and its requester.
interface mult_seq_8bits_if #(
    parameter int unsigned WIDTH = mult_pkg::DEF_WIDTH
);
    logic             start;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic [WIDTH-1:0] S;
    logic             ov_mult;
    logic             busy;
    logic             done;

    modport master (output start, A, B, input S, ov_mult, busy, done);
    modport slave  (input start, A, B, output S, ov_mult, busy, done);
endinterface

// File: rtl/mult_datapath.sv
// Shift-add datapath: operand shifters, product accumulator and iteration counter.
module mult_datapath
    import mult_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH,
    parameter int unsigned CNT_W = DEF_CNT_W
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               i_load,
    input  logic               i_step,
    input  logic [WIDTH-1:0]   i_a,
    input  logic [WIDTH-1:0]   i_b,
    output logic [2*WIDTH-1:0] o_prod_next_c,
    output logic               o_last_c
);

    localparam int unsigned PW = 2 * WIDTH;

    logic [PW-1:0]    r_a;
    logic [WIDTH-1:0] r_b;
    logic [PW-1:0]    r_prod;
    logic [CNT_W-1:0] r_cnt;
    logic [PW-1:0]    w_prod_next;

    // Product including this iteration's partial term; the top samples it on the last step.
    assign w_prod_next   = r_b[0] ? (r_prod + r_a) : r_prod;
    assign o_prod_next_c = w_prod_next;
    assign o_last_c      = (r_cnt == CNT_W'(WIDTH - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a    <= '0;
            r_b    <= '0;
            r_prod <= '0;
            r_cnt  <= '0;
        end else if (i_load) begin
            r_a    <= PW'(i_a);
            r_b    <= i_b;
            r_prod <= '0;
            r_cnt  <= '0;
        end else if (i_step) begin
            r_prod <= w_prod_next;
            r_a    <= r_a << 1;
            r_b    <= r_b >> 1;
            r_cnt  <= r_cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/mult_seq_8bits.sv
// Sequential unsigned multiplier: FSM plus the held result/overflow registers feeding the ALU.
module mult_seq_8bits
    import mult_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH,
    parameter int unsigned CNT_W = DEF_CNT_W
) (
    input  logic                   clk,
    input  logic                   rst_n,
    mult_seq_8bits_if.slave        bus
);

    state_t             r_state;
    logic [WIDTH-1:0]   r_s;
    logic               r_ov;
    logic               w_load;
    logic               w_step;
    logic               w_last;
    logic [2*WIDTH-1:0] w_prod_next;

    assign w_load = (r_state == IDLE) && bus.start;
    assign w_step = (r_state == CALC);

    mult_datapath #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) u_dp (
        .clk           (clk),
        .rst_n         (rst_n),
        .i_load        (w_load),
        .i_step        (w_step),
        .i_a           (bus.A),
        .i_b           (bus.B),
        .o_prod_next_c (w_prod_next),
        .o_last_c      (w_last)
    );

    // Result registers move only on the CALC->DONE edge and hold otherwise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_s     <= '0;
            r_ov    <= 1'b0;
        end else begin
            case (r_state)
                IDLE: if (bus.start) r_state <= CALC;
                CALC: if (w_last) begin
                    r_s     <= w_prod_next[WIDTH-1:0];
                    r_ov    <= |w_prod_next[2*WIDTH-1:WIDTH];
                    r_state <= DONE;
                end
                DONE:    r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.S       = r_s;
    assign bus.ov_mult = r_ov;
    assign bus.busy    = (r_state == CALC);
    assign bus.done    = (r_state == DONE);

endmodule
